// File: rtl/mux_bit_serializer_if.sv
// Bus bundle between the bit serializer and its surroundings.
// Carries the byte-input handshake, the 8-to-1 mux data/select/return
// wires, and the serial output handshake.
//   slave  : serializer side (consumes in_*, ser_ready, mux_out)
//   master : environment side (upstream producer, mux, downstream consumer)
interface mux_bit_serializer_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] mux_data;
  logic [SEL_W-1:0]  mux_sel;
  logic              mux_out;
  logic              ser_valid;
  logic              ser_ready;
  logic              ser_bit;
  logic              ser_last;

  modport slave (
    input  in_valid, in_data, mux_out, ser_ready,
    output in_ready, mux_data, mux_sel, ser_valid, ser_bit, ser_last
  );

  modport master (
    output in_valid, in_data, mux_out, ser_ready,
    input  in_ready, mux_data, mux_sel, ser_valid, ser_bit, ser_last
  );
endinterface

// File: rtl/mux_bit_serializer.sv
// Byte-to-bit serializer built around an external 8-to-1 bit-select mux.
// Captures a byte on in_valid/in_ready, holds it on mux_data, steps mux_sel
// once per accepted serial beat and forwards mux_out as ser_bit, with
// ser_last on the final beat and an optional trailing parity beat.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : handshake / mux bundle (slave modport)
//   busy : high whenever the serializer is not idle
module mux_bit_serializer #(
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_bit_serializer_if.slave   bus,
  output logic                  busy
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned ST_W   = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
  localparam logic [ST_W-1:0] ST_PAR   = 2'd2;

  localparam logic [SEL_W-1:0] SEL_START = LSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [SEL_W-1:0] CNT_LAST  = 3'd7;

  logic [ST_W-1:0]   state_q,     state_d;
  logic [DATA_W-1:0] data_q,      data_d;
  logic [SEL_W-1:0]  sel_q,       sel_d;
  logic [SEL_W-1:0]  cnt_q,       cnt_d;
  logic              par_q,       par_d;
  logic              in_ready_q,  in_ready_d;
  logic              ser_valid_q, ser_valid_d;
  logic              ser_last_q,  ser_last_d;
  logic              busy_q,      busy_d;

  // Next-state and next-output decode; outputs are registered from state_d.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    in_ready_d  = 1'b0;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          data_d  = bus.in_data;
          sel_d   = SEL_START;
          cnt_d   = '0;
          par_d   = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.ser_ready) begin
          par_d = par_q ^ bus.mux_out;
          cnt_d = cnt_q + 3'd1;
          // Select wraps after the 8th beat; the wrapped value is never used.
          sel_d = LSB_FIRST ? (sel_q + 3'd1) : (sel_q - 3'd1);
          if (cnt_q == CNT_LAST) begin
            state_d = PARITY_EN ? ST_PAR : ST_IDLE;
          end
        end
      end
      ST_PAR: begin
        if (bus.ser_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    ser_valid_d = (state_d != ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    ser_last_d  = (state_d == ST_PAR) ||
                  ((state_d == ST_SHIFT) && (cnt_d == CNT_LAST) && !PARITY_EN);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      sel_q       <= SEL_START;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      in_ready_q  <= in_ready_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
    end
  end

  // Data beats pass the mux output straight through; the parity beat
  // substitutes the accumulated parity.
  assign bus.ser_bit   = (state_q == ST_PAR) ? (par_q ^ PARITY_ODD) : bus.mux_out;
  assign bus.mux_data  = data_q;
  assign bus.mux_sel   = sel_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_last  = ser_last_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mux_bit_serializer.sv
// Bench for mux_bit_serializer: four instances cover LSB/MSB order and
// parity off/even/odd; each is paired with an 8-to-1 mux model and checked
// beat by beat against an expected bit list built from the byte.
module tb_mux_bit_serializer;

  localparam int unsigned N_DUT = 4;
  localparam int unsigned BOUND = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid  [N_DUT];
  logic [7:0] in_data   [N_DUT];
  logic       ser_ready [N_DUT];
  logic       in_ready  [N_DUT];
  logic [7:0] mux_data  [N_DUT];
  logic [2:0] mux_sel   [N_DUT];
  logic       ser_valid [N_DUT];
  logic       ser_bit   [N_DUT];
  logic       ser_last  [N_DUT];
  logic       busy      [N_DUT];

  int tests = 0;
  int fails = 0;
  int cur_k = 0;

  // Instance k: k==1 is MSB-first, k>=2 has parity, k==3 is odd parity.
  for (genvar k = 0; k < N_DUT; k++) begin : g_dut
    localparam bit LSB  = (k != 1);
    localparam bit PEN  = (k >= 2);
    localparam bit PODD = (k == 3);

    mux_bit_serializer_if bus ();

    assign bus.in_valid  = in_valid[k];
    assign bus.in_data   = in_data[k];
    assign bus.ser_ready = ser_ready[k];
    assign bus.mux_out   = bus.mux_data[bus.mux_sel];
    assign in_ready[k]   = bus.in_ready;
    assign mux_data[k]   = bus.mux_data;
    assign mux_sel[k]    = bus.mux_sel;
    assign ser_valid[k]  = bus.ser_valid;
    assign ser_bit[k]    = bus.ser_bit;
    assign ser_last[k]   = bus.ser_last;

    mux_bit_serializer #(
      .LSB_FIRST  (LSB),
      .PARITY_EN  (PEN),
      .PARITY_ODD (PODD)
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy[k])
    );
  end

  function automatic bit cfg_lsb(input int k);
    return k != 1;
  endfunction
  function automatic bit cfg_pen(input int k);
    return k >= 2;
  endfunction
  function automatic bit cfg_odd(input int k);
    return k == 3;
  endfunction

  // Expected beat list for one byte.
  logic exp_bit  [9];
  logic exp_last [9];
  int   exp_idx  [9];
  int   nbeats;

  task automatic build_model(input int k, input logic [7:0] b);
    int idx;
    for (int i = 0; i < 8; i++) begin
      idx         = cfg_lsb(k) ? i : 7 - i;
      exp_idx[i]  = idx;
      exp_bit[i]  = b[idx];
      exp_last[i] = (i == 7) && !cfg_pen(k);
    end
    nbeats = 8;
    if (cfg_pen(k)) begin
      exp_idx[8]  = -1;
      exp_bit[8]  = (^b) ^ cfg_odd(k);
      exp_last[8] = 1'b1;
      nbeats      = 9;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input int k);
    cur_k = k;
    check("rst_in_ready",  32'(in_ready[k]),  32'd1);
    check("rst_ser_valid", 32'(ser_valid[k]), 32'd0);
    check("rst_ser_last",  32'(ser_last[k]),  32'd0);
    check("rst_busy",      32'(busy[k]),      32'd0);
    check("rst_mux_data",  32'(mux_data[k]),  32'd0);
    check("rst_mux_sel",   32'(mux_sel[k]),   cfg_lsb(k) ? 32'd0 : 32'd7);
  endtask

  // Push one byte into instance k and check every cycle until it is idle again.
  task automatic send_byte(input int k, input logic [7:0] b, input int stall_at,
                           input int stall_len, input bit rand_bp,
                           input bit hold_valid, input int abort_at);
    int beat, cyc, stalls, stall_cnt;
    logic rdy;
    cur_k = k;
    build_model(k, b);
    @(negedge clk);
    check("pre_in_ready",  32'(in_ready[k]),  32'd1);
    check("pre_ser_valid", 32'(ser_valid[k]), 32'd0);
    in_valid[k]  = 1'b1;
    in_data[k]   = b;
    ser_ready[k] = 1'b0;
    @(posedge clk);
    beat = 0; cyc = 0; stalls = 0; stall_cnt = 0;
    while (beat < nbeats && cyc < int'(BOUND)) begin
      @(negedge clk);
      cyc++;
      if (hold_valid) in_data[k] = 8'($urandom);
      else            in_valid[k] = 1'b0;
      check("ser_valid", 32'(ser_valid[k]), 32'd1);
      check("in_ready",  32'(in_ready[k]),  32'd0);
      check("busy",      32'(busy[k]),      32'd1);
      check("mux_data",  32'(mux_data[k]),  32'(b));
      check("ser_bit",   32'(ser_bit[k]),   32'(exp_bit[beat]));
      check("ser_last",  32'(ser_last[k]),  32'(exp_last[beat]));
      if (exp_idx[beat] >= 0)
        check("mux_sel", 32'(mux_sel[k]), 32'(exp_idx[beat]));
      if (beat == abort_at) begin
        rst = 1'b1;
        ser_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid[k]  = 1'b0;
        ser_ready[k] = 1'b0;
        check_reset_vals(k);
        return;
      end
      rdy = 1'b1;
      if (beat == stall_at && stall_cnt < stall_len) begin
        rdy = 1'b0;
        stall_cnt++;
      end else if (rand_bp) begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      ser_ready[k] = rdy;
      if (!rdy) stalls++;
      @(posedge clk);
      if (rdy) beat++;
    end
    check("beats_done", 32'(beat), 32'(nbeats));
    check("byte_cycles", 32'(cyc), 32'(nbeats + stalls));
    @(negedge clk);
    in_valid[k]  = 1'b0;
    ser_ready[k] = 1'b0;
    check("end_in_ready",  32'(in_ready[k]),  32'd1);
    check("end_ser_valid", 32'(ser_valid[k]), 32'd0);
    check("end_ser_last",  32'(ser_last[k]),  32'd0);
    check("end_busy",      32'(busy[k]),      32'd0);
  endtask

  initial begin
    for (int i = 0; i < int'(N_DUT); i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = 8'h00;
      ser_ready[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < int'(N_DUT); i++) check_reset_vals(i);

    // LSB-first and MSB-first, no backpressure.
    send_byte(0, 8'hA5, -1, 0, 1'b0, 1'b0, -1);
    send_byte(1, 8'h81, -1, 0, 1'b0, 1'b0, -1);
    // Three-cycle stall on beat 4.
    send_byte(0, 8'h3C, 3, 3, 1'b0, 1'b0, -1);
    // Parity beats: even, odd, and all-zero even.
    send_byte(2, 8'h07, -1, 0, 1'b0, 1'b0, -1);
    send_byte(3, 8'h07, -1, 0, 1'b0, 1'b0, -1);
    send_byte(2, 8'h00, -1, 0, 1'b0, 1'b0, -1);
    // Reset while presenting beat 5, then a clean byte.
    send_byte(0, 8'hFF, -1, 0, 1'b0, 1'b0, 4);
    send_byte(0, 8'h01, -1, 0, 1'b0, 1'b0, -1);
    send_byte(1, 8'hFF, -1, 0, 1'b0, 1'b0, 2);
    send_byte(1, 8'h6E, -1, 0, 1'b0, 1'b0, -1);
    // in_valid held high with churning in_data while busy.
    send_byte(0, 8'hC3, -1, 0, 1'b0, 1'b1, -1);
    send_byte(3, 8'h5A, 1, 2, 1'b0, 1'b1, -1);
    // Random bytes with random backpressure on every configuration.
    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k < int'(N_DUT); k++) begin
        send_byte(k, 8'($urandom), -1, 0, 1'b1, bit'($urandom_range(0, 1)), -1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
